// File: rtl/alk_pkg.sv
// alk_pkg: shared types and constants for the ALK multiply/divide sequencer
// and the ALKC flag stage that decodes its ALU requests.
//   md_state_t       : sequencer state encoding
//   alu_req_t        : per-step ALU operation request encoding
//   MD_STEPS_DEFAULT : iterations per MUL/DIV operation
//   MD_CNT_W_DEFAULT : default step-counter width
package alk_pkg;

  localparam int unsigned MD_STEPS_DEFAULT = 32;
  localparam int unsigned MD_CNT_W_DEFAULT = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } md_state_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_req_t;

  // Non-restoring divide: a negative partial remainder (borrow) is corrected
  // by adding the divisor on the next step, otherwise keep subtracting.
  function automatic alu_req_t div_req(input logic prev_borrow);
    return prev_borrow ? ALU_ADD : ALU_SUB;
  endfunction

endpackage

// File: rtl/alk_mdcnt.sv
// alk_mdcnt: MUL/DIV step counter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous clear (priority over i_en)
//   i_en           : advance one step
//   o_cnt          : current iteration index
//   o_tc           : terminal count, high when o_cnt == STEPS-1
module alk_mdcnt
  import alk_pkg::*;
#(
  parameter int unsigned STEPS = MD_STEPS_DEFAULT,
  parameter int unsigned CNT_W = MD_CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Step index register; the sequencer never enables it past STEPS-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CNT_W'(STEPS - 1));

endmodule

// File: rtl/alk_mdseq.sv
// alk_mdseq: multiply/divide step sequencer feeding the ALKC flag stage.
// Runs STEPS shift/add (MUL) or non-restoring shift/subtract (DIV) iterations,
// an optional restoring FIXUP add after DIV, then pulses md_done_h.
//   qdclk_l, reset_l  : clock (rising edge), async active-low reset
//   md_start_h        : start request (accepted only in IDLE)
//   md_div_h          : 1 = DIV, 0 = MUL, sampled with the start
//   ustall_h          : freeze all state and outputs
//   md_abort_h        : return to IDLE, overrides stall and start
//   alkc_flag_h       : borrow/carry of the previous step
//   mplier_lsb_h      : multiplier bit shifted out in the previous step
//   alpctl_mul_l      : low during MUL/DIV steps
//   alu_01xx_h        : ADD request
//   alu_sub_op_h      : SUB request
//   q_bit_h           : quotient bit of the latest DIV step
//   md_busy_h         : sequence in progress
//   md_done_h         : one-cycle completion pulse
//   step_cnt_h        : current iteration index
module alk_mdseq
  import alk_pkg::*;
#(
  parameter int unsigned STEPS = MD_STEPS_DEFAULT,
  parameter int unsigned CNT_W = MD_CNT_W_DEFAULT
) (
  input  logic             qdclk_l,
  input  logic             reset_l,
  input  logic             md_start_h,
  input  logic             md_div_h,
  input  logic             ustall_h,
  input  logic             md_abort_h,
  input  logic             alkc_flag_h,
  input  logic             mplier_lsb_h,
  output logic             alpctl_mul_l,
  output logic             alu_01xx_h,
  output logic             alu_sub_op_h,
  output logic             q_bit_h,
  output logic             md_busy_h,
  output logic             md_done_h,
  output logic [CNT_W-1:0] step_cnt_h
);

  md_state_t        r_state;
  logic             r_alpctl_l;
  logic             r_add;
  logic             r_sub;
  logic             r_q;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_stepping;
  logic             w_div_add;

  assign w_stepping = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign w_div_add  = (div_req(alkc_flag_h) == ALU_ADD);

  // Counter clears on an accepted start, on leaving DONE and on abort;
  // it holds at STEPS-1 through FIXUP/DONE so the last index stays visible.
  assign w_cnt_clr = md_abort_h ||
                     (!ustall_h && (((r_state == ST_IDLE) && md_start_h) ||
                                    (r_state == ST_DONE)));
  assign w_cnt_en  = !md_abort_h && !ustall_h && w_stepping && !w_tc;

  alk_mdcnt #(
    .STEPS (STEPS),
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk   (qdclk_l),
    .i_rst_n (reset_l),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  // Sequencer state and registered outputs; each transition loads the
  // outputs that belong to the state being entered.
  always_ff @(posedge qdclk_l or negedge reset_l) begin
    if (!reset_l) begin
      r_state    <= ST_IDLE;
      r_alpctl_l <= 1'b1;
      r_add      <= 1'b0;
      r_sub      <= 1'b0;
      r_q        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (md_abort_h) begin
      r_state    <= ST_IDLE;
      r_alpctl_l <= 1'b1;
      r_add      <= 1'b0;
      r_sub      <= 1'b0;
      r_q        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (!ustall_h) begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (md_start_h) begin
            r_busy     <= 1'b1;
            r_alpctl_l <= 1'b0;
            r_q        <= 1'b0;
            if (md_div_h) begin
              // First divide step always subtracts.
              r_state <= ST_DIV;
              r_add   <= 1'b0;
              r_sub   <= 1'b1;
            end else begin
              r_state <= ST_MUL;
              r_add   <= mplier_lsb_h;
              r_sub   <= 1'b0;
            end
          end
        end
        ST_MUL: begin
          if (w_tc) begin
            r_state    <= ST_DONE;
            r_alpctl_l <= 1'b1;
            r_add      <= 1'b0;
            r_sub      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_add <= mplier_lsb_h;
            r_sub <= 1'b0;
          end
        end
        ST_DIV: begin
          r_q <= ~alkc_flag_h;
          if (w_tc) begin
            r_alpctl_l <= 1'b1;
            r_sub      <= 1'b0;
            if (alkc_flag_h) begin
              // Final remainder negative: one restoring add.
              r_state <= ST_FIXUP;
              r_add   <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_add   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_add <= w_div_add;
            r_sub <= ~w_div_add;
          end
        end
        ST_FIXUP: begin
          r_state <= ST_DONE;
          r_add   <= 1'b0;
          r_sub   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_alpctl_l <= 1'b1;
          r_add      <= 1'b0;
          r_sub      <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign alpctl_mul_l = r_alpctl_l;
  assign alu_01xx_h   = r_add;
  assign alu_sub_op_h = r_sub;
  assign q_bit_h      = r_q;
  assign md_busy_h    = r_busy;
  assign md_done_h    = r_done;
  assign step_cnt_h   = w_cnt;

endmodule
